ltc2324_sdo_deserializer: RTL and testbench



---
 rtl/ltc2324_sdo_deserializer.sv | 169 ++++++++++++++++
 tb/tb_ltc2324_sdo_deserializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ltc2324_sdo_deserializer.sv
// ltc2324_sdo_deserializer
// Receive side of the LTC2324 front end. It captures one MSB-first
// DATA_WIDTH-bit word per SDO lane for each conversion frame. Framing comes
// from the pulse generator: rx_start arms a frame, sck_gate (delayed by
// SAMPLE_DELAY clocks) qualifies the bit samples, and data_latch transfers
// the completed words to the parallel output bus.
// Optional build macro: OFFSET_BINARY_EN. When it is defined, the MSB of each
// lane word is inverted on transfer, which turns two's complement into
// offset binary.
module ltc2324_sdo_deserializer #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLE_DELAY = 2    // legal 1..7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_start,
  input  logic                            sck_gate,
  input  logic                            data_latch,
  input  logic [NUM_LANES-1:0]            sdo,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic                            data_valid,
  output logic                            frame_err,
  output logic                            overrun_err,
  output logic                            busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lanes_t;

  state_e                  state_q;
  logic                    rx_start_q;
  logic                    data_latch_q;
  logic [SAMPLE_DELAY-1:0] sck_pipe_q;
  lanes_t                  shreg_q;
  lanes_t                  shift_d;
  lanes_t                  latch_word_d;
  lanes_t                  data_out_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    data_valid_q;
  logic                    frame_err_q;
  logic                    overrun_err_q;
  logic                    busy_q;

  logic rx_rise;
  logic latch_rise;
  logic sck_gate_d;
  logic sample_en;

  // Register the strobe inputs and delay sck_gate so that sampling lines up with the SDO round trip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_start_q   <= 1'b0;
      data_latch_q <= 1'b0;
      sck_pipe_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read last cycle's value, so the loop order does not matter.
      rx_start_q    <= rx_start;
      data_latch_q  <= data_latch;
      sck_pipe_q[0] <= sck_gate;
      for (int k = 1; k < SAMPLE_DELAY; k++) begin
        sck_pipe_q[k] <= sck_pipe_q[k-1];
      end
    end
  end

  assign rx_rise    = rx_start & ~rx_start_q;
  assign latch_rise = data_latch & ~data_latch_q;
  assign sck_gate_d = sck_pipe_q[SAMPLE_DELAY-1];
  assign sample_en  = (state_q == ST_SHIFT) && sck_gate_d;

  // Compute the next shifted value and the word to present on transfer for every lane.
  always_comb begin
    // NOTE: both outputs get a full default first, so every path assigns them and no latch is inferred.
    shift_d      = shreg_q;
    latch_word_d = shreg_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      shift_d[i] = {shreg_q[i][DATA_WIDTH-2:0], sdo[i]};
`ifdef OFFSET_BINARY_EN
      latch_word_d[i][DATA_WIDTH-1] = ~shreg_q[i][DATA_WIDTH-1];
`endif
    end
  end

  // Frame FSM: arm, shift, and transfer, with registered strobes and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_rise) begin
            state_q   <= ST_SHIFT;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (rx_rise) begin
            // A new frame pre-empts the partial one, so the partial data is dropped.
            overrun_err_q <= 1'b1;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
          end else if (latch_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end else if (sample_en) begin
            shreg_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_LAST) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (latch_rise) begin
            // The transfer wins over a simultaneous re-arm, which then starts cleanly with no overrun.
            data_out_q   <= latch_word_d;
            data_valid_q <= 1'b1;
            if (rx_rise) begin
              state_q   <= ST_SHIFT;
              bit_cnt_q <= '0;
              shreg_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (rx_rise) begin
            overrun_err_q <= 1'b1;
            state_q       <= ST_SHIFT;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ltc2324_sdo_deserializer.sv
// tb_ltc2324_sdo_deserializer
// The stimulus side pushes each expected output event into a queue. An
// independent monitor pops one entry for every cycle in which the DUT pulses
// data_valid, frame_err or overrun_err, and it compares the flags and data_out.
module tb_ltc2324_sdo_deserializer;

  localparam int NL = 4;
  localparam int DW = 16;
  localparam int SD = 2;
  localparam int XW = NL * DW + 3;

  typedef logic [NL-1:0][DW-1:0] words_t;
  typedef struct {
    logic [2:0]    flags;   // {data_valid, frame_err, overrun_err}
    logic [NL*DW-1:0] data;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               rx_start;
  logic               sck_gate;
  logic               data_latch;
  logic [NL-1:0]      sdo;
  logic [NL*DW-1:0]   data_out;
  logic               data_valid;
  logic               frame_err;
  logic               overrun_err;
  logic               busy;

  exp_t   exp_q[$];
  words_t model_out;
  int     pass_cnt;
  int     total_cnt;

  ltc2324_sdo_deserializer #(
    .NUM_LANES   (NL),
    .DATA_WIDTH  (DW),
    .SAMPLE_DELAY(SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_start   (rx_start),
    .sck_gate   (sck_gate),
    .data_latch (data_latch),
    .sdo        (sdo),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Word that data_out should carry after a transfer, including the optional MSB inversion.
  function automatic words_t xfer(input words_t w);
    words_t r = w;
`ifdef OFFSET_BINARY_EN
    for (int i = 0; i < NL; i++) r[i][DW-1] = ~w[i][DW-1];
`endif
    return r;
  endfunction

  task automatic push(input logic [2:0] flags, input words_t d);
    exp_t e;
    e.flags = flags;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_rx();
    @(negedge clk) rx_start = 1'b1;
    @(negedge clk) rx_start = 1'b0;
  endtask

  task automatic pulse_latch();
    @(negedge clk) data_latch = 1'b1;
    @(negedge clk) data_latch = 1'b0;
  endtask

  // Open sck_gate for ngate cycles and drive SDO bits SD cycles later. Bits past the word are driven as 1.
  task automatic run_gate(input words_t w, input int ngate);
    for (int t = 0; t < ngate + SD + 1; t++) begin
      int b;
      sck_gate = (t < ngate);
      b = t - SD;
      for (int i = 0; i < NL; i++) begin
        if (b >= 0 && b < ngate) sdo[i] = (b < DW) ? w[i][DW-1-b] : 1'b1;
        else sdo[i] = 1'b0;
      end
      @(negedge clk);
    end
    sck_gate = 1'b0;
    sdo      = '0;
  endtask

  // Monitor: every output event must match the next expectation in the queue.
  always @(negedge clk) begin
    if (rst_n && (data_valid || frame_err || overrun_err)) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_event: got flags=%b data=%h expected none",
                 {data_valid, frame_err, overrun_err}, data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event", {data_valid, frame_err, overrun_err, data_out}, {e.flags, e.data});
      end
    end
  end

  initial begin
    words_t w_nom, w_a5, w_ext, w_x, w_y;
    w_nom = {16'h0000, 16'hFFFF, 16'h1234, 16'h8001};
    w_a5  = {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    w_ext = {16'h7FFF, 16'hFEDC, 16'h2468, 16'h1357};
    w_x   = {16'h0F0F, 16'hC3C3, 16'h5555, 16'h8000};
    w_y   = {16'h1111, 16'h2222, 16'h4444, 16'h7FFF};
    pass_cnt   = 0;
    total_cnt  = 0;
    model_out  = '0;
    rst_n      = 1'b0;
    rx_start   = 1'b0;
    sck_gate   = 1'b0;
    data_latch = 1'b0;
    sdo        = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", XW'(busy), XW'(0));
    check("reset_data_out", XW'(data_out), XW'(0));
    check("reset_flags", XW'({data_valid, frame_err, overrun_err}), XW'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frame.
    pulse_rx();
    run_gate(w_nom, 16);
    model_out = xfer(w_nom);
    push(3'b100, model_out);
    pulse_latch();
    repeat (3) @(negedge clk);

    // Short frame: 12 bits, then a latch gives a frame error and data_out is held.
    pulse_rx();
    run_gate(w_a5, 12);
    push(3'b010, model_out);
    pulse_latch();
    repeat (3) @(negedge clk);

    // Overrun after 8 bits, then a full A5A5 frame.
    pulse_rx();
    run_gate(w_nom, 8);
    push(3'b001, model_out);
    pulse_rx();
    run_gate(w_a5, 16);
    model_out = xfer(w_a5);
    push(3'b100, model_out);
    pulse_latch();
    repeat (3) @(negedge clk);

    // Extra SCK: 20 gate cycles, and only the first 16 bits are kept.
    pulse_rx();
    run_gate(w_ext, 20);
    model_out = xfer(w_ext);
    push(3'b100, model_out);
    pulse_latch();
    repeat (3) @(negedge clk);

    // Latch and re-arm in the same cycle while DONE: old frame latched, no overrun, next frame armed.
    pulse_rx();
    run_gate(w_x, 16);
    model_out = xfer(w_x);
    push(3'b100, model_out);
    @(negedge clk);
    data_latch = 1'b1;
    rx_start   = 1'b1;
    @(negedge clk);
    data_latch = 1'b0;
    rx_start   = 1'b0;
    run_gate(w_y, 16);
    model_out = xfer(w_y);
    push(3'b100, model_out);
    pulse_latch();
    repeat (3) @(negedge clk);

    // Reset after 5 bits: outputs clear at once and a later latch produces nothing.
    pulse_rx();
    run_gate(w_nom, 5);
    check("mid_busy", XW'(busy), XW'(1));
    rst_n = 1'b0;
    #1;
    check("rst_data_out", XW'(data_out), XW'(0));
    check("rst_flags", XW'({data_valid, frame_err, overrun_err}), XW'(0));
    check("rst_busy", XW'(busy), XW'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    model_out = '0;
    pulse_latch();
    repeat (5) @(negedge clk);

    check("queue_empty", XW'(exp_q.size()), XW'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
